// File: rtl/hog_ctrl_pkg.sv
// Shared definitions for the HOG frame controller: state codes and the
// bit layout of the status word read back over the lightweight bridge.
package hog_ctrl_pkg;

   // State codes are visible to software through status_pio[2:0].
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STREAM = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } ctrl_state_t;

   // status_pio field positions
   localparam int STAT_STATE_LSB = 0;
   localparam int STAT_STATE_W   = 3;
   localparam int STAT_ERR_BIT   = 3;
   localparam int STAT_FRAME_LSB = 4;
   localparam int STAT_FRAME_W   = 8;
   localparam int STAT_PIX_LSB   = 12;
   localparam int STAT_PIX_W     = 19;
   localparam int STAT_RSVD_BIT  = 31;

   // Assemble the status word; the reserved top bit always reads 0.
   function automatic logic [31:0] pack_status(
      input ctrl_state_t             st,
      input logic [STAT_FRAME_W-1:0] frm,
      input logic [STAT_PIX_W-1:0]   pix
   );
      logic [31:0] w;
      w = '0;
      w[STAT_STATE_LSB +: STAT_STATE_W] = st;
      w[STAT_ERR_BIT]                   = (st == ST_ERROR);
      w[STAT_FRAME_LSB +: STAT_FRAME_W] = frm;
      w[STAT_PIX_LSB +: STAT_PIX_W]     = pix;
      w[STAT_RSVD_BIT]                  = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/hog_frame_ctrl_idle_timer.sv
// Consecutive-quiet-cycle counter. expired fires combinationally on the
// LIMIT-th consecutive tick so the owner can change state on that same edge.
module idle_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   // LIMIT-1 is the largest value ever held, which always fits in clog2(LIMIT) bits.
   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

   logic [CW-1:0] cnt;

   assign expired = tick && !clear && (cnt == CW'(LIMIT - 1));

   // Count quiet cycles; clear dominates, and the count restarts after expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (tick)
         cnt <= expired ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/hog_frame_ctrl.sv
// Frame sequencer sitting between a pixel source and the HOG core.
// Streams exactly one frame of pixels, waits for the core's outputs to go
// quiet, then pulses frame_done. A stalled source trips a watchdog into ERROR.
module hog_frame_ctrl
   import hog_ctrl_pkg::*;
#(
   parameter int IMG_W          = 640,
   parameter int IMG_H          = 480,
   parameter int LEVELS         = 7,
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int DRAIN_IDLE     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_start,
   input  logic              cmd_abort,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [7:0]        src_pixel,
   output logic              hog_in_valid,
   input  logic              hog_in_ready,
   output logic [7:0]        hog_in_pixel,
   input  logic [LEVELS-1:0] hog_out_valid,
   input  logic [LEVELS-1:0] hog_out_ready,
   output logic              frame_done,
   output logic              busy,
   output logic [31:0]       status_pio
);

   localparam int NPIX    = IMG_W * IMG_H;
   localparam int PIX_NAT = $clog2(NPIX + 1);
   localparam int PIX_W   = (PIX_NAT > STAT_PIX_W) ? PIX_NAT : STAT_PIX_W;

   ctrl_state_t       state;
   logic [PIX_W-1:0]  pixel_cnt;
   logic [7:0]        frame_cnt;

   logic streaming;
   logic in_xfer;
   logic out_xfer;
   logic last_pix;
   logic wd_expired;
   logic dr_expired;

   // The handshake is a pure pass-through while streaming; gating with rst
   // drops it the instant reset asserts, independent of the state register.
   assign streaming    = (state == ST_STREAM) && !rst;
   assign hog_in_valid = streaming && src_valid;
   assign src_ready    = streaming && hog_in_ready;
   assign hog_in_pixel = src_pixel;

   assign in_xfer  = hog_in_valid && hog_in_ready;
   assign out_xfer = |(hog_out_valid & hog_out_ready);
   assign last_pix = in_xfer && (pixel_cnt == PIX_W'(NPIX - 1));

   // Input-stall watchdog: runs only in STREAM, restarted by every transfer.
   idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state != ST_STREAM) || in_xfer),
      .tick    ((state == ST_STREAM) && !in_xfer),
      .expired (wd_expired)
   );

   // Drain quiet detector: runs only in DRAIN, restarted by any output beat.
   idle_timer #(.LIMIT(DRAIN_IDLE)) u_drain (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state != ST_DRAIN) || out_xfer),
      .tick    ((state == ST_DRAIN) && !out_xfer),
      .expired (dr_expired)
   );

   // Frame sequencer; abort overrides everything and leaves counters intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pixel_cnt <= '0;
         frame_cnt <= '0;
      end else if (cmd_abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_start) begin
                  state     <= ST_STREAM;
                  pixel_cnt <= '0;
               end
            end
            ST_STREAM: begin
               // A transfer always beats the watchdog, including on the last pixel.
               if (in_xfer) begin
                  pixel_cnt <= pixel_cnt + 1'b1;
                  if (last_pix)
                     state <= ST_DRAIN;
               end else if (wd_expired) begin
                  state <= ST_ERROR;
               end
            end
            ST_DRAIN: begin
               if (dr_expired)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               frame_cnt <= frame_cnt + 1'b1;
               state     <= ST_IDLE;
            end
            ST_ERROR: state <= ST_ERROR;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Status outputs decode straight from registered state and counters.
   assign frame_done = (state == ST_DONE);
   assign busy       = (state == ST_STREAM) || (state == ST_DRAIN);
   assign status_pio = pack_status(state, frame_cnt, pixel_cnt[STAT_PIX_W-1:0]);

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Bench for hog_frame_ctrl: directed scenarios plus a randomized soak, all
// checked every cycle against a behavioural frame model.
module tb_hog_frame_ctrl;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 2;
   localparam int LEVELS = 7;
   localparam int TO     = 16;
   localparam int DI     = 4;
   localparam int NPIX   = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_start = 1'b0;
   logic              cmd_abort = 1'b0;
   logic              src_valid = 1'b0;
   logic              src_ready;
   logic [7:0]        src_pixel = 8'h00;
   logic              hog_in_valid;
   logic              hog_in_ready = 1'b0;
   logic [7:0]        hog_in_pixel;
   logic [LEVELS-1:0] hog_out_valid = '0;
   logic [LEVELS-1:0] hog_out_ready = '0;
   logic              frame_done;
   logic              busy;
   logic [31:0]       status_pio;

   int total = 0;
   int bad   = 0;

   // behavioural model: state code, pixels, frames, current quiet run
   int m_st = 0, m_pix = 0, m_frm = 0, m_quiet = 0;

   int   xfer_cnt = 0;
   logic [7:0] got_q[$];

   hog_frame_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .LEVELS(LEVELS),
      .TIMEOUT_CYCLES(TO), .DRAIN_IDLE(DI)
   ) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
      .src_valid(src_valid), .src_ready(src_ready), .src_pixel(src_pixel),
      .hog_in_valid(hog_in_valid), .hog_in_ready(hog_in_ready),
      .hog_in_pixel(hog_in_pixel), .hog_out_valid(hog_out_valid),
      .hog_out_ready(hog_out_ready), .frame_done(frame_done), .busy(busy),
      .status_pio(status_pio)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Compare DUT against the model mid-cycle, then advance the model using
   // the inputs that the coming clock edge will see.
   always @(negedge clk) begin
      logic [43:0] got, exp;
      logic [31:0] est;
      logic        oxfer, xfer;
      got = {hog_in_valid, src_ready, hog_in_pixel, frame_done, busy, status_pio};
      if (rst) begin
         exp = {1'b0, 1'b0, src_pixel, 1'b0, 1'b0, 32'h0};
      end else begin
         est = {1'b0, 19'(m_pix), 8'(m_frm), (m_st == 4), 3'(m_st)};
         exp = {(m_st == 1) && src_valid, (m_st == 1) && hog_in_ready, src_pixel,
                (m_st == 3), (m_st == 1) || (m_st == 2), est};
      end
      chk("cycle_outputs", 64'(got), 64'(exp));
      if (hog_in_valid && hog_in_ready) begin
         xfer_cnt++;
         got_q.push_back(hog_in_pixel);
      end
      if (rst) begin
         m_st = 0; m_pix = 0; m_frm = 0; m_quiet = 0;
      end else begin
         xfer  = (m_st == 1) && src_valid && hog_in_ready;
         oxfer = |(hog_out_valid & hog_out_ready);
         if (cmd_abort) m_st = 0;
         else case (m_st)
            0: if (cmd_start) begin m_st = 1; m_pix = 0; m_quiet = 0; end
            1: if (xfer) begin
                  m_pix++; m_quiet = 0;
                  if (m_pix == NPIX) m_st = 2;
               end else begin
                  m_quiet++;
                  if (m_quiet == TO) m_st = 4;
               end
            2: if (oxfer) m_quiet = 0;
               else begin
                  m_quiet++;
                  if (m_quiet == DI) begin m_st = 3; m_quiet = 0; end
               end
            3: begin m_frm = (m_frm + 1) % 256; m_st = 0; end
            default: ;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (status_pio[2:0] != 3'd0 && n < 40) begin tick(); n++; end
      if (n >= 40) chk({nm, "_idle_timeout"}, 64'(status_pio[2:0]), 64'd0);
   endtask

   task automatic run_frame();
      int n = 0;
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1; hog_in_ready = 1'b1;
      repeat (NPIX) begin src_pixel = 8'($urandom); tick(); end
      src_valid = 1'b0;
      while (!frame_done && n < 20) begin tick(); n++; end
      if (n >= 20) chk("frame_timeout", 64'(n), 64'd0);
      tick();
   endtask

   initial begin
      int n;
      logic [7:0] exp_px;
      int sv_pct;

      // reset state
      repeat (3) tick();
      chk("reset_status", 64'(status_pio), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick();

      // S1: clean frame, drain takes 4 quiet cycles, frame count becomes 1
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1; hog_in_ready = 1'b1;
      repeat (NPIX) begin src_pixel = 8'($urandom); tick(); end
      src_valid = 1'b0;
      chk("s1_in_drain", 64'(status_pio[2:0]), 64'd2);
      chk("s1_pix8", 64'(status_pio[30:12]), 64'd8);
      n = 0;
      while (!frame_done && n < 20) begin tick(); n++; end
      chk("s1_drain_len", 64'(n), 64'd4);
      tick();
      chk("s1_frame_cnt", 64'(status_pio[11:4]), 64'd1);
      chk("s1_idle", 64'(status_pio[2:0]), 64'd0);

      // S2: ready toggling; source holds each pixel until it is taken
      xfer_cnt = 0; got_q.delete();
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 2 * NPIX; c++) begin
         src_pixel = 8'hA0 + 8'(n);
         hog_in_ready = (c % 2 == 0);
         tick();
         if (c % 2 == 0) n++;
      end
      src_valid = 1'b0; hog_in_ready = 1'b0;
      chk("s2_xfers", 64'(xfer_cnt), 64'd8);
      chk("s2_qlen", 64'(got_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         exp_px = 8'hA0 + 8'(i);
         chk("s2_pixel_order", 64'(got_q[i]), 64'(exp_px));
      end
      wait_idle("s2");

      // S3: stall after 3 pixels trips the watchdog on the 16th quiet cycle
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1; hog_in_ready = 1'b1;
      repeat (3) begin src_pixel = 8'($urandom); tick(); end
      src_valid = 1'b0;
      repeat (TO - 1) tick();
      chk("s3_still_stream", 64'(status_pio[2:0]), 64'd1);
      tick();
      chk("s3_error_state", 64'(status_pio[2:0]), 64'd4);
      chk("s3_err_flag", 64'(status_pio[3]), 64'd1);
      chk("s3_pix3", 64'(status_pio[30:12]), 64'd3);
      repeat (5) tick();
      chk("s3_error_held", 64'(status_pio[2:0]), 64'd4);
      cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
      chk("s3_abort_idle", 64'(status_pio[2:0]), 64'd0);
      chk("s3_abort_keeps_pix", 64'(status_pio[30:12]), 64'd3);

      // S4: output beat every 3rd drain cycle keeps DRAIN alive
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1; hog_in_ready = 1'b1;
      repeat (NPIX) begin src_pixel = 8'($urandom); tick(); end
      src_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         hog_out_valid = (c % 3 == 2) ? 7'b0001000 : 7'b0000110;
         hog_out_ready = (c % 3 == 2) ? 7'b0001000 : 7'b0000001;
         tick();
      end
      chk("s4_still_drain", 64'(status_pio[2:0]), 64'd2);
      hog_out_valid = '0; hog_out_ready = '0;
      n = 0;
      while (!frame_done && n < 20) begin tick(); n++; end
      chk("s4_quiet_len", 64'(n), 64'd4);
      tick();
      chk("s4_frame_cnt", 64'(status_pio[11:4]), 64'd3);

      // S5: start+abort together in IDLE; start ignored in STREAM
      cmd_start = 1'b1; cmd_abort = 1'b1; tick();
      cmd_start = 1'b0; cmd_abort = 1'b0;
      chk("s5_stay_idle", 64'(status_pio[2:0]), 64'd0);
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1; hog_in_ready = 1'b1;
      repeat (2) begin src_pixel = 8'($urandom); tick(); end
      cmd_start = 1'b1; tick(); cmd_start = 1'b0; src_valid = 1'b0;
      chk("s5_start_ignored_pix", 64'(status_pio[30:12]), 64'd3);
      chk("s5_start_ignored_st", 64'(status_pio[2:0]), 64'd1);
      cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;

      // S6: frame counter wraps (3 frames so far, 253 more)
      repeat (253) run_frame();
      chk("s6_wrap", 64'(status_pio[11:4]), 64'd0);

      // async reset mid-STREAM drops everything before any clock edge
      cmd_start = 1'b1; tick(); cmd_start = 1'b0;
      src_valid = 1'b1; hog_in_ready = 1'b1;
      repeat (2) begin src_pixel = 8'($urandom); tick(); end
      chk("rst_pre_valid", 64'(hog_in_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_outs", 64'({hog_in_valid, src_ready, frame_done, busy, status_pio}), 64'd0);
      tick(); tick();
      rst = 1'b0; src_valid = 1'b0; hog_in_ready = 1'b0;
      tick();

      // randomized soak
      sv_pct = 90;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) sv_pct = ($urandom_range(0, 3) == 0) ? 5 : 90;
         cmd_start     = ($urandom_range(0, 7) == 0);
         cmd_abort     = ($urandom_range(0, 63) == 0);
         src_valid     = ($urandom_range(0, 99) < sv_pct);
         hog_in_ready  = ($urandom_range(0, 1) == 1);
         src_pixel     = 8'($urandom);
         hog_out_valid = ($urandom_range(0, 5) == 0) ? LEVELS'($urandom) : '0;
         hog_out_ready = LEVELS'($urandom);
         tick();
      end
      cmd_start = 1'b0; cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
